// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and the port controller state type.
//   RF_ADDR_W       - register address width
//   RF_DATA_W       - register data width
//   RF_DEPTH        - number of architectural registers
//   rf_ctrl_state_t - controller state: CLEAR (sweep in progress) or RUN
package rf_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_ctrl_state_t;

endpackage

// File: rtl/rf_bypass_port.sv
// rf_bypass_port: one read port of the regfile port controller.
// Registers the decode read address alongside the regfile's own registered
// read, then selects the operand returned to the pipeline:
//   x0 -> zero, else forwarded write-back data (bypass build), else regfile data.
// Build option: REGFILE_BYPASS_EN adds the write-back forwarding path.
// Ports:
//   clock, reset       - clock and synchronous active-high reset
//   run                - controller is in RUN (bypass build only)
//   wb_set, wb_addr,
//   wb_data            - pipeline write-back request (bypass build only)
//   rd_addr            - decode-stage source address
//   rf_out             - regfile registered read data for this port
//   data               - corrected operand, valid one cycle after rd_addr
module rf_bypass_port
    import rf_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
`ifdef REGFILE_BYPASS_EN
    input  logic                 run,
    input  logic                 wb_set,
    input  logic [RF_ADDR_W-1:0] wb_addr,
    input  logic [RF_DATA_W-1:0] wb_data,
`endif
    input  logic [RF_ADDR_W-1:0] rd_addr,
    input  logic [RF_DATA_W-1:0] rf_out,
    output logic [RF_DATA_W-1:0] data
);

    // ---- p0 -> p1: capture address (and bypass decision) with the regfile read
    logic [RF_ADDR_W-1:0] addr_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_p1 <= '0;
        end else begin
            addr_p1 <= rd_addr;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic                 hit_p1;
    logic [RF_DATA_W-1:0] wb_data_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_p1 <= 1'b0;
        end else begin
            hit_p1 <= run && wb_set && (wb_addr == rd_addr) && (wb_addr != '0);
        end
    end

    // Data register carries no reset; hit_p1 gates its use.
    always_ff @(posedge clock) begin
        wb_data_p1 <= wb_data;
    end

    // ---- p1: operand select
    always_comb begin
        data = rf_out;
        if (addr_p1 == '0) begin
            data = '0;
        end else if (hit_p1) begin
            data = wb_data_p1;
        end
    end
`else
    // ---- p1: operand select (same-cycle write returns the old value)
    always_comb begin
        data = rf_out;
        if (addr_p1 == '0) begin
            data = '0;
        end
    end
`endif

endmodule

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: front end between the pipeline and a 32x32 regfile with
// one write port and two registered read ports.
// After reset it sweeps CLEAR_VALUE into every register (CLEAR), then passes
// write-backs through with x0 writes suppressed (RUN). Read operands come back
// one cycle after the address, with x0 forced to zero.
// Build option: REGFILE_BYPASS_EN forwards a same-cycle write-back to reads.
// Ports:
//   clock, reset            - clock and synchronous active-high reset
//   wb_set, wb_addr, wb_data- pipeline write-back request
//   rd1_addr, rd2_addr      - decode-stage source addresses
//   rf_set, rf_rw_addr,
//   rf_rw_in                - regfile write port drive
//   rf_r1_addr, rf_r2_addr  - regfile read addresses
//   rf_r1_out, rf_r2_out    - regfile registered read data
//   r1_data, r2_data        - corrected operands to the pipeline
//   ready                   - clear sweep complete
//   wb_drop                 - sticky: a write-back arrived before ready
module regfile_port_ctrl
    import rf_pkg::*;
#(
    parameter logic [RF_DATA_W-1:0] CLEAR_VALUE = 32'h0000_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wb_set,
    input  logic [RF_ADDR_W-1:0] wb_addr,
    input  logic [RF_DATA_W-1:0] wb_data,
    input  logic [RF_ADDR_W-1:0] rd1_addr,
    input  logic [RF_ADDR_W-1:0] rd2_addr,
    output logic                 rf_set,
    output logic [RF_ADDR_W-1:0] rf_rw_addr,
    output logic [RF_DATA_W-1:0] rf_rw_in,
    output logic [RF_ADDR_W-1:0] rf_r1_addr,
    output logic [RF_ADDR_W-1:0] rf_r2_addr,
    input  logic [RF_DATA_W-1:0] rf_r1_out,
    input  logic [RF_DATA_W-1:0] rf_r2_out,
    output logic [RF_DATA_W-1:0] r1_data,
    output logic [RF_DATA_W-1:0] r2_data,
    output logic                 ready,
    output logic                 wb_drop
);

    localparam logic [RF_ADDR_W-1:0] LAST_ADDR = RF_ADDR_W'(RF_DEPTH - 1);

    rf_ctrl_state_t       state;
    logic [RF_ADDR_W-1:0] clr_cnt;

    // ---- control state: clear sweep and sticky drop flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            wb_drop <= 1'b0;
        end else begin
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state <= RUN;
                end
                if (wb_set) begin
                    wb_drop <= 1'b1;
                end
            end
        end
    end

    assign ready = (state == RUN);

    // ---- p0: write port drive; write-backs are ignored during the sweep
    always_comb begin
        rf_set     = wb_set && (wb_addr != '0);
        rf_rw_addr = wb_addr;
        rf_rw_in   = wb_data;
        if (state == CLEAR) begin
            rf_set     = 1'b1;
            rf_rw_addr = clr_cnt;
            rf_rw_in   = CLEAR_VALUE;
        end
    end

    assign rf_r1_addr = rd1_addr;
    assign rf_r2_addr = rd2_addr;

    // ---- p1: per-port operand correction
    rf_bypass_port u_port1 (
        .clock   (clock),
        .reset   (reset),
`ifdef REGFILE_BYPASS_EN
        .run     (ready),
        .wb_set  (wb_set),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
`endif
        .rd_addr (rd1_addr),
        .rf_out  (rf_r1_out),
        .data    (r1_data)
    );

    rf_bypass_port u_port2 (
        .clock   (clock),
        .reset   (reset),
`ifdef REGFILE_BYPASS_EN
        .run     (ready),
        .wb_set  (wb_set),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
`endif
        .rd_addr (rd2_addr),
        .rf_out  (rf_r2_out),
        .data    (r2_data)
    );

endmodule
